mixer_seq_ctrl: RTL and testbench
=================================

# mixer_seq_ctrl

Wishbone-configured power-up and calibration sequencer for the analog mixer in the user project area. It sits between the management-SoC Wishbone bus and the mixer's digital control pins. It holds the mixer's configuration registers and steps the mixer through bias enable, LO enable and calibration with programmable settle times. It reports completion or timeout through a status register and an interrupt line.

## Interface
Parameters:
- ADDR_BASE, 32'h3000_0000, register block base; decode on adr[31:8] == ADDR_BASE[31:8]
- CNT_W, 16, width of settle and timeout counters

Ports:
- wb_clk_i  in  1  single clock domain
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1 each  Wishbone classic cycle, strobe, write enable
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  transfer acknowledge
- mix_bias_en  out  1  mixer bias enable
- mix_lo_en  out  1  LO buffer enable
- mix_cal_start  out  1  calibration request, held high while in CAL
- mix_gain  out  4  gain code
- mix_cal_done  in  1  calibration done from the analog side; asynchronous, 2-flop synchronized
- irq  out  1  level interrupt

## Operation
Registers (offset from base, all 32-bit; unlisted bits read 0):
- 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 ABORT (write-1 pulse, reads 0), bit2 IRQ_EN (R/W)
- 0x04 GAIN[3:0], R/W, drives mix_gain directly
- 0x08 SETTLE[CNT_W-1:0], R/W, reset 16'd1000
- 0x0C STATUS: [2:0] state code, bit4 DONE (sticky, W1C), bit5 TIMEOUT (sticky, W1C)
- 0x10 CAL_TO[CNT_W-1:0], R/W, reset 16'd50000; 0 disables the timeout
- Unmapped offsets inside the block are acked, read 0, and ignore writes. Addresses outside the block are not acked.
- wbs_sel_i masks writes byte-wise on all R/W fields.

FSM, with state codes:
- IDLE=0: all enables 0. START -> BIAS.
- BIAS=1: bias_en=1. After max(SETTLE,1) cycles -> LO.
- LO=2: bias_en=1, lo_en=1. After max(SETTLE,1) cycles -> CAL.
- CAL=3: bias_en, lo_en and cal_start all 1.
  - Synchronized cal_done=1 -> RUN; set DONE.
  - If CAL_TO != 0 and CAL_TO cycles elapse without done -> FAULT; set TIMEOUT.
- RUN=4: bias_en=1, lo_en=1, cal_start=0. Stays here until ABORT.
- FAULT=5: all enables 0. START -> BIAS.
- ABORT from any state -> IDLE; enables drop on the next edge.
- Same-write START+ABORT: ABORT wins.
- START is ignored in BIAS, LO, CAL and RUN.
- SETTLE and CAL_TO are sampled when a counter is loaded; writes mid-count do not affect the running count.

irq = IRQ_EN & (DONE | TIMEOUT).

## Timing
- Reset: every output is 0, wbs_dat_o = 0, state IDLE, GAIN=0, IRQ_EN=0, DONE=TIMEOUT=0. Outputs go low asynchronously on reset assertion. Reset mid-sequence aborts immediately.
- Wishbone: ack rises one cycle after cyc&stb is sampled and lasts one cycle. It is not reasserted in the cycle after an ack, so each access takes at least 2 cycles. Read data is valid in the ack cycle.
- Write side effects take place at the clock edge that asserts ack, call it T. The FSM is in BIAS from T+1, so mix_bias_en is high at T+1.
- BIAS lasts exactly max(SETTLE,1) cycles, and LO the same.
- cal_done latency: 2 sync cycles, plus 1 cycle to reach RUN.
- W1C write and a same-cycle set event: the set wins.

## Test plan
- Reset, then read all registers -> SETTLE=1000, CAL_TO=50000, all others 0; all mixer outputs 0; irq=0.
- SETTLE=4, IRQ_EN=1, START, cal_done raised 10 cycles after cal_start rises -> bias_en high 4 cycles before lo_en; cal_start high; RUN reached 3 cycles after cal_done; STATUS=0x14; irq=1. W1C of DONE -> irq=0.
- CAL_TO=20, cal_done held 0 -> FAULT exactly 20 cycles after CAL entry; all enables 0; STATUS=0x25. START then recovers to BIAS.
- ABORT written during LO, and separately START+ABORT in one write from IDLE -> IDLE; enables 0 next cycle; no sequence starts.
- SETTLE=0 -> BIAS and LO each last 1 cycle. START written in RUN -> ignored, state stays 4.
- wb_rst_i asserted mid-CAL -> outputs 0 without a clock edge; byte-masked write sel=4'b0001 of 0xFFFF to SETTLE -> reads 0x03FF (1000 = 0x03E8 with its low byte set to 0xFF).

Source files
------------

// File: rtl/mixer_seq_ctrl.sv
// mixer_seq_ctrl: Wishbone register block and power-up/calibration sequencer
// for the analog mixer. Steps bias -> LO -> calibration with programmable
// settle time and calibration timeout, and reports the outcome via STATUS/irq.
module mixer_seq_ctrl #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        mix_bias_en,
  output logic        mix_lo_en,
  output logic        mix_cal_start,
  output logic [3:0]  mix_gain,
  input  logic        mix_cal_done,
  output logic        irq
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_LO    = 3'd2,
    ST_CAL   = 3'd3,
    ST_RUN   = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_GAIN   = 8'h04;
  localparam logic [7:0] OFF_SETTLE = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_CAL_TO = 8'h10;

  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_RST = CNT_W'(1000);
  localparam logic [CNT_W-1:0] CAL_TO_RST = CNT_W'(50000);

  // Bus side
  logic             ack_reg;
  logic [31:0]      dat_reg;
  logic [31:0]      rd_data;
  logic [31:0]      wmask;
  logic             blk_sel;
  logic             wb_hit;
  logic             wr_en;
  logic             wr_ctrl;
  logic             wr_gain;
  logic             wr_settle;
  logic             wr_status;
  logic             wr_cal_to;

  // Configuration / status registers
  logic             irq_en_reg;
  logic [3:0]       gain_reg;
  logic [CNT_W-1:0] settle_reg;
  logic [CNT_W-1:0] cal_to_reg;
  logic             done_reg;
  logic             timeout_reg;
  logic [CNT_W-1:0] settle_merged;
  logic [CNT_W-1:0] cal_to_merged;
  logic [3:0]       gain_merged;

  // Sequencer
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             to_en_reg, to_en_next;
  logic             done_set;
  logic             to_set;
  logic             start_req;
  logic             abort_req;
  logic             done_clr;
  logic             to_clr;
  logic [CNT_W-1:0] settle_ld;
  logic             sync1_reg, sync2_reg;

  // Byte-enable expansion used to merge writes into every R/W field
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_mask
      assign wmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  // A new access is only taken when no ack is pending, so every transfer
  // spends at least one idle cycle after its ack.
  assign blk_sel   = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign wb_hit    = wbs_cyc_i & wbs_stb_i & blk_sel & ~ack_reg;
  assign wr_en     = wb_hit & wbs_we_i;
  assign wr_ctrl   = wr_en & (wbs_adr_i[7:0] == OFF_CTRL) & wbs_sel_i[0];
  assign wr_gain   = wr_en & (wbs_adr_i[7:0] == OFF_GAIN);
  assign wr_settle = wr_en & (wbs_adr_i[7:0] == OFF_SETTLE);
  assign wr_status = wr_en & (wbs_adr_i[7:0] == OFF_STATUS) & wbs_sel_i[0];
  assign wr_cal_to = wr_en & (wbs_adr_i[7:0] == OFF_CAL_TO);

  // ABORT dominates START when both bits arrive in one write.
  assign abort_req = wr_ctrl & wbs_dat_i[1];
  assign start_req = wr_ctrl & wbs_dat_i[0] & ~wbs_dat_i[1];
  assign done_clr  = wr_status & wbs_dat_i[4];
  assign to_clr    = wr_status & wbs_dat_i[5];

  assign gain_merged   = (gain_reg & ~wmask[3:0]) | (wbs_dat_i[3:0] & wmask[3:0]);
  assign settle_merged = (settle_reg & ~wmask[CNT_W-1:0]) |
                         (wbs_dat_i[CNT_W-1:0] & wmask[CNT_W-1:0]);
  assign cal_to_merged = (cal_to_reg & ~wmask[CNT_W-1:0]) |
                         (wbs_dat_i[CNT_W-1:0] & wmask[CNT_W-1:0]);

  // A settle of 0 behaves like 1: the phase still occupies one cycle.
  assign settle_ld = (settle_reg == CNT_ZERO) ? CNT_ZERO : settle_reg - CNT_ONE;

  // Read mux; unmapped offsets inside the block read as zero
  always_comb begin
    rd_data = 32'd0;
    case (wbs_adr_i[7:0])
      OFF_CTRL:   rd_data = {29'd0, irq_en_reg, 2'b00};
      OFF_GAIN:   rd_data = {28'd0, gain_reg};
      OFF_SETTLE: rd_data = 32'(settle_reg);
      OFF_STATUS: rd_data = {26'd0, timeout_reg, done_reg, 1'b0, state_reg};
      OFF_CAL_TO: rd_data = 32'(cal_to_reg);
      default:    rd_data = 32'd0;
    endcase
  end

  // Bus acknowledge and registered read data (held at zero outside ack)
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_reg <= 1'b0;
      dat_reg <= 32'd0;
    end else begin
      ack_reg <= wb_hit;
      dat_reg <= (wb_hit && !wbs_we_i) ? rd_data : 32'd0;
    end
  end

  // Configuration registers with byte-masked writes
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_en_reg <= 1'b0;
      gain_reg   <= 4'd0;
      settle_reg <= SETTLE_RST;
      cal_to_reg <= CAL_TO_RST;
    end else begin
      if (wr_ctrl)   irq_en_reg <= wbs_dat_i[2];
      if (wr_gain)   gain_reg   <= gain_merged;
      if (wr_settle) settle_reg <= settle_merged;
      if (wr_cal_to) cal_to_reg <= cal_to_merged;
    end
  end

  // Sticky status flags; a set event in the same cycle beats a W1C clear
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      done_reg    <= done_set | (done_reg & ~done_clr);
      timeout_reg <= to_set | (timeout_reg & ~to_clr);
    end
  end

  // Two-flop synchronizer for the analog calibration-done flag
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= mix_cal_done;
      sync2_reg <= sync1_reg;
    end
  end

  // Sequencer state, phase counter and latched timeout enable
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= CNT_ZERO;
      to_en_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      to_en_reg <= to_en_next;
    end
  end

  // Next-state logic: counters load on phase entry so mid-count register
  // writes only affect the next load.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    to_en_next = to_en_reg;
    done_set   = 1'b0;
    to_set     = 1'b0;
    if (abort_req) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_FAULT: begin
          if (start_req) begin
            state_next = ST_BIAS;
            cnt_next   = settle_ld;
          end
        end
        ST_BIAS: begin
          if (cnt_reg == CNT_ZERO) begin
            state_next = ST_LO;
            cnt_next   = settle_ld;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
        ST_LO: begin
          if (cnt_reg == CNT_ZERO) begin
            state_next = ST_CAL;
            cnt_next   = cal_to_reg - CNT_ONE;
            to_en_next = (cal_to_reg != CNT_ZERO);
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
        ST_CAL: begin
          if (sync2_reg) begin
            state_next = ST_RUN;
            done_set   = 1'b1;
          end else if (to_en_reg && cnt_reg == CNT_ZERO) begin
            state_next = ST_FAULT;
            to_set     = 1'b1;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
        ST_RUN:  state_next = ST_RUN;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Mixer pins decode straight from the registered state so reset clears
  // them without waiting for a clock edge.
  assign mix_bias_en   = (state_reg == ST_BIAS) || (state_reg == ST_LO) ||
                         (state_reg == ST_CAL)  || (state_reg == ST_RUN);
  assign mix_lo_en     = (state_reg == ST_LO) || (state_reg == ST_CAL) ||
                         (state_reg == ST_RUN);
  assign mix_cal_start = (state_reg == ST_CAL);
  assign mix_gain      = gain_reg;
  assign irq           = irq_en_reg & (done_reg | timeout_reg);
  assign wbs_ack_o     = ack_reg;
  assign wbs_dat_o     = dat_reg;

endmodule

// File: tb/tb_mixer_seq_ctrl.sv
// Testbench for mixer_seq_ctrl: directed Wishbone scenarios, a cycle-indexed
// behavioural model of the sequence timeline, and a per-cycle output compare.
module tb_mixer_seq_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int BIG = 1 << 30;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0;
  logic [31:0] wbs_dat_i = 32'd0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        mix_bias_en;
  logic        mix_lo_en;
  logic        mix_cal_start;
  logic [3:0]  mix_gain;
  logic        mix_cal_done = 1'b0;
  logic        irq;

  mixer_seq_ctrl #(.ADDR_BASE(BASE), .CNT_W(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .mix_bias_en(mix_bias_en), .mix_lo_en(mix_lo_en),
    .mix_cal_start(mix_cal_start), .mix_gain(mix_gain),
    .mix_cal_done(mix_cal_done), .irq(irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cycle = 0;
  always @(posedge wb_clk_i) cycle <= cycle + 1;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  // ---------------- model: sequence described as a timeline ----------------
  bit          m_seq;          // a sequence timeline is active
  logic [2:0]  m_rest;         // state code when no timeline is active
  int          m_s, m_n, m_to; // start cycle, phase length, timeout length
  int          m_d;            // cycle cal_done was raised
  bit          m_d_valid;
  bit          m_done_b, m_to_b;
  int          m_dclr, m_tclr; // events at or before these cycles were cleared
  bit          m_irq_en;
  logic [3:0]  m_gain;
  logic [15:0] m_settle, m_calto;

  function automatic void model_reset();
    m_seq = 0; m_rest = 3'd0; m_d_valid = 0; m_d = 0;
    m_done_b = 0; m_to_b = 0; m_dclr = -BIG; m_tclr = -BIG;
    m_irq_en = 0; m_gain = 4'd0; m_settle = 16'd1000; m_calto = 16'd50000;
    m_s = 0; m_n = 1; m_to = 0;
  endfunction

  function automatic int cal_entry();
    return m_s + 2 * m_n;
  endfunction

  function automatic int raw_run();
    int e;
    e = cal_entry();
    if (!m_d_valid) return BIG;
    return (m_d + 3 > e + 1) ? m_d + 3 : e + 1;
  endfunction

  function automatic int raw_fault();
    return (m_to == 0) ? BIG : cal_entry() + m_to;
  endfunction

  function automatic int ev_run();
    return (raw_run() <= raw_fault()) ? raw_run() : BIG;
  endfunction

  function automatic int ev_fault();
    return (raw_run() <= raw_fault()) ? BIG : raw_fault();
  endfunction

  function automatic logic [2:0] m_state(input int c);
    int k;
    if (!m_seq) return m_rest;
    k = c - m_s;
    if (k < m_n) return 3'd1;
    if (k < 2 * m_n) return 3'd2;
    if (c >= ev_run()) return 3'd4;
    if (c >= ev_fault()) return 3'd5;
    return 3'd3;
  endfunction

  function automatic bit m_done(input int c);
    return m_done_b | (m_seq && ev_run() <= c && ev_run() > m_dclr);
  endfunction

  function automatic bit m_tof(input int c);
    return m_to_b | (m_seq && ev_fault() <= c && ev_fault() > m_tclr);
  endfunction

  function automatic void fold(input int c);
    m_done_b = m_done(c);
    m_to_b   = m_tof(c);
    m_rest   = m_state(c);
    m_seq    = 0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_reg(input logic [7:0] off, input int c);
    case (off)
      8'h00: return {29'd0, m_irq_en, 2'b00};
      8'h04: return {28'd0, m_gain};
      8'h08: return {16'd0, m_settle};
      8'h0C: return {26'd0, m_tof(c), m_done(c), 1'b0, m_state(c)};
      8'h10: return {16'd0, m_calto};
      default: return 32'd0;
    endcase
  endfunction

  // w is the first cycle in which the write's effects are visible
  function automatic void model_write(input logic [7:0] off, input logic [31:0] dat,
                                      input logic [3:0] sel, input int w);
    logic [31:0] m;
    logic [2:0]  p;
    case (off)
      8'h00: if (sel[0]) begin
        m_irq_en = dat[2];
        p = m_state(w - 1);
        if (dat[1]) begin
          fold(w - 1); m_rest = 3'd0;
        end else if (dat[0] && (p == 3'd0 || p == 3'd5)) begin
          fold(w - 1);
          m_seq = 1; m_s = w;
          m_n = (m_settle == 16'd0) ? 1 : int'(m_settle);
          m_to = int'(m_calto);
          if (mix_cal_done) begin m_d = w - 10; m_d_valid = 1; end
          else m_d_valid = 0;
        end
      end
      8'h04: begin m = merge({28'd0, m_gain}, dat, sel); m_gain = m[3:0]; end
      8'h08: begin m = merge({16'd0, m_settle}, dat, sel); m_settle = m[15:0]; end
      8'h0C: if (sel[0]) begin
        if (dat[4]) begin m_done_b = 0; m_dclr = w - 1; end
        if (dat[5]) begin m_to_b = 0; m_tclr = w - 1; end
      end
      8'h10: begin m = merge({16'd0, m_calto}, dat, sel); m_calto = m[15:0]; end
      default: ;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  // Per-cycle compare of the mixer pins and irq against the model
  logic [2:0] cmp_st;
  always @(negedge wb_clk_i) begin
    if (check_en && !wb_rst_i) begin
      cmp_st = m_state(cycle);
      chk("cyc_bias_en", mix_bias_en, (cmp_st >= 3'd1 && cmp_st <= 3'd4));
      chk("cyc_lo_en", mix_lo_en, (cmp_st >= 3'd2 && cmp_st <= 3'd4));
      chk("cyc_cal_start", mix_cal_start, (cmp_st == 3'd3));
      chk("cyc_gain", mix_gain, m_gain);
      chk("cyc_irq", irq, m_irq_en & (m_done(cycle) | m_tof(cycle)));
    end
  end

  task automatic tick();
    @(posedge wb_clk_i); #1;
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output bit acked);
    wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = dat; wbs_sel_i = sel;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    acked = 0; rdat = 32'd0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin acked = 1; rdat = wbs_dat_o; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    bit a;
    wb_xfer(BASE | {24'd0, off}, 1'b1, dat, sel, r, a);
    $display("wr off=0x%02h dat=0x%08h sel=%b ack=%0d cycle=%0d", off, dat, sel, a, cycle);
    chk("wr_ack", a, 1);
    if (a) model_write(off, dat, sel, cycle);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    bit a;
    wb_xfer(BASE | {24'd0, off}, 1'b0, 32'd0, 4'hF, d, a);
    $display("rd off=0x%02h dat=0x%08h ack=%0d cycle=%0d", off, d, a, cycle);
    chk("rd_ack", a, 1);
    if (a) chk($sformatf("rd_model_%02h", off), d, model_reg(off, cycle - 1));
  endtask

  task automatic raise_done();
    mix_cal_done = 1'b1; m_d = cycle; m_d_valid = 1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] d;
    bit a;
    model_reset();
    #1 wb_rst_i = 1'b1;
    #1;
    chk("rst_bias", mix_bias_en, 0);
    chk("rst_lo", mix_lo_en, 0);
    chk("rst_cal", mix_cal_start, 0);
    chk("rst_gain", mix_gain, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ack", wbs_ack_o, 0);
    chk("rst_dat", wbs_dat_o, 0);
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    check_en = 1;

    // Register reset values
    rd(8'h00, d); chk("rst_ctrl", d, 32'h0);
    rd(8'h04, d); chk("rst_gainreg", d, 32'h0);
    rd(8'h08, d); chk("rst_settle", d, 32'd1000);
    rd(8'h0C, d); chk("rst_status", d, 32'h0);
    rd(8'h10, d); chk("rst_calto", d, 32'd50000);
    rd(8'h14, d); chk("unmapped_rd", d, 32'h0);
    wb_xfer(BASE + 32'h100, 1'b0, 32'd0, 4'hF, d, a);
    $display("rd adr=0x%08h ack=%0d cycle=%0d", BASE + 32'h100, a, cycle);
    chk("outside_no_ack", a, 0);

    // Gain and byte enables
    wr(8'h04, 32'hA, 4'hF); chk("gain_lit", mix_gain, 4'hA);
    wr(8'h04, 32'h5, 4'h0); chk("gain_sel0", mix_gain, 4'hA);

    // Normal sequence: SETTLE=4, IRQ_EN, cal_done 10 cycles into CAL
    wr(8'h08, 32'd4, 4'hF);
    wr(8'h00, 32'h4, 4'hF);
    wr(8'h00, 32'h5, 4'hF);
    chk("seq_bias_T1", mix_bias_en, 1);
    chk("seq_lo_T1", mix_lo_en, 0);
    repeat (3) tick(); chk("seq_lo_late", mix_lo_en, 0);
    tick(); chk("seq_lo_on", mix_lo_en, 1);
    chk("seq_cal_early", mix_cal_start, 0);
    repeat (4) tick(); chk("seq_cal_on", mix_cal_start, 1);
    repeat (10) tick(); raise_done();
    tick(); tick(); chk("seq_cal_hold", mix_cal_start, 1);
    tick(); chk("seq_run_cal", mix_cal_start, 0);
    chk("seq_run_lo", mix_lo_en, 1);
    rd(8'h0C, d); chk("seq_status", d, 32'h14);
    chk("seq_irq", irq, 1);
    mix_cal_done = 1'b0;
    wr(8'h0C, 32'h10, 4'hF); chk("w1c_irq", irq, 0);
    rd(8'h0C, d); chk("w1c_status", d, 32'h04);

    // Timeout path
    wr(8'h00, 32'h6, 4'hF); chk("abort_run_bias", mix_bias_en, 0);
    wr(8'h10, 32'd20, 4'hF);
    wr(8'h00, 32'h5, 4'hF);
    repeat (8) tick(); chk("to_cal_entry", mix_cal_start, 1);
    repeat (19) tick(); chk("to_cal_19", mix_cal_start, 1);
    tick(); chk("to_fault_cal", mix_cal_start, 0);
    chk("to_fault_bias", mix_bias_en, 0);
    chk("to_fault_lo", mix_lo_en, 0);
    rd(8'h0C, d); chk("to_status", d, 32'h25);
    chk("to_irq", irq, 1);
    wr(8'h00, 32'h5, 4'hF); chk("fault_restart", mix_bias_en, 1);
    rd(8'h0C, d); chk("restart_status", d, 32'h21);

    // ABORT during LO
    repeat (3) tick(); chk("in_lo", mix_lo_en, 1);
    wr(8'h00, 32'h6, 4'hF);
    chk("abort_lo_bias", mix_bias_en, 0);
    chk("abort_lo_lo", mix_lo_en, 0);
    repeat (12) tick(); chk("abort_stays", mix_bias_en, 0);
    rd(8'h0C, d); chk("abort_status", d, 32'h20);
    wr(8'h0C, 32'h20, 4'hF);

    // START+ABORT together from IDLE
    wr(8'h00, 32'h7, 4'hF); chk("sa_bias", mix_bias_en, 0);
    repeat (3) tick(); chk("sa_bias_later", mix_bias_en, 0);
    rd(8'h0C, d); chk("sa_status", d, 32'h0);
    chk("sa_irq", irq, 0);

    // SETTLE=0 and START ignored in RUN
    wr(8'h08, 32'd0, 4'hF);
    wr(8'h00, 32'h5, 4'hF);
    chk("s0_bias", mix_bias_en, 1); chk("s0_lo", mix_lo_en, 0);
    tick(); chk("s0_lo_on", mix_lo_en, 1); chk("s0_cal_off", mix_cal_start, 0);
    tick(); chk("s0_cal_on", mix_cal_start, 1);
    raise_done();
    repeat (4) tick(); chk("s0_run", mix_cal_start, 0);
    wr(8'h00, 32'h5, 4'hF);
    rd(8'h0C, d); chk("run_start_ignored", d, 32'h14);
    mix_cal_done = 1'b0;

    // Reset mid-CAL, then byte-masked SETTLE write
    wr(8'h00, 32'h6, 4'hF);
    wr(8'h08, 32'd2, 4'hF);
    wr(8'h00, 32'h5, 4'hF);
    repeat (5) tick(); chk("pre_rst_cal", mix_cal_start, 1);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("arst_bias", mix_bias_en, 0);
    chk("arst_lo", mix_lo_en, 0);
    chk("arst_cal", mix_cal_start, 0);
    chk("arst_gain", mix_gain, 0);
    chk("arst_irq", irq, 0);
    model_reset();
    repeat (2) @(posedge wb_clk_i);
    #3 wb_rst_i = 1'b0;
    rd(8'h0C, d); chk("post_rst_status", d, 32'h0);
    wr(8'h08, 32'hFFFF, 4'b0001);
    rd(8'h08, d); chk("settle_bytemask", d, 32'h3FF);
    repeat (3) tick();

    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
